// File: rtl/fft_stage_seq.sv
// Butterfly address sequencer for an in-place radix-2 DIF CORDIC FFT.
// Optional bit-reversed unload phase is enabled by defining FFT_CTRL_BITREV_EN.
module fft_stage_seq #(
    parameter int LOG2N    = 5,
    parameter int PIPE_LAT = 6
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_hold,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(LOG2N)-1:0]      o_stage,
    output logic                          o_rd_en,
    output logic [LOG2N-1:0]              o_rd_addr_a,
    output logic [LOG2N-1:0]              o_rd_addr_b,
    output logic [LOG2N-2:0]              o_tw_addr,
    output logic                          o_wr_en,
    output logic [LOG2N-1:0]              o_wr_addr_a,
    output logic [LOG2N-1:0]              o_wr_addr_b,
    output logic                          o_out_valid,
    output logic [LOG2N-1:0]              o_out_addr
);
    localparam int N     = 2 ** LOG2N;
    localparam int H_MAX = N / 2;
    localparam int STG_W = $clog2(LOG2N);
    localparam int BW    = LOG2N - 1;
    localparam int DW    = $clog2(PIPE_LAT + 1);

    // Handshake: strobes are qualified by ~i_hold; a strobe transfers only in a cycle with i_hold=0.
`ifdef FFT_CTRL_BITREV_EN
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, UNLOAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
`endif

    state_t             state;
    logic [STG_W-1:0]   stage;
    logic [BW-1:0]      b_cnt;
    logic [DW-1:0]      d_cnt;
    logic               busy;
    logic               done;
    logic               rd_v;
    logic [LOG2N-1:0]   rd_a;
    logic [LOG2N-1:0]   rd_b;
    logic [BW-1:0]      tw;
    logic               pv [PIPE_LAT];
    logic [LOG2N-1:0]   pa [PIPE_LAT];
    logic [LOG2N-1:0]   pb [PIPE_LAT];

    logic [STG_W-1:0]   sel_s;
    logic [BW-1:0]      sel_b;
    logic [LOG2N-1:0]   c_half;
    logic [LOG2N-1:0]   c_a;
    logic [LOG2N-1:0]   c_b;
    logic [BW-1:0]      c_tw;
    logic [LOG2N-1:0]   bw_ext;

    // Butterfly to be presented on the next active edge: DRAIN looks ahead to stage+1, b=0.
    always_comb begin
        sel_s = stage;
        sel_b = b_cnt;
        if (state == IDLE) begin
            sel_s = '0;
            sel_b = '0;
        end else if (state == DRAIN) begin
            sel_s = stage + STG_W'(1);
            sel_b = '0;
        end
        bw_ext = {1'b0, sel_b};
        c_half = LOG2N'(1) << (LOG2N - 1 - int'(sel_s));
        c_a    = ((bw_ext & ~(c_half - LOG2N'(1))) << 1) | (bw_ext & (c_half - LOG2N'(1)));
        c_b    = c_a | c_half;
        c_tw   = BW'((bw_ext & (c_half - LOG2N'(1))) << sel_s);
    end

`ifdef FFT_CTRL_BITREV_EN
    logic               ov;
    logic [LOG2N-1:0]   oa;
    logic [LOG2N-1:0]   cur_n;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int k = 0; k < LOG2N; k++) r[k] = v[LOG2N-1-k];
        return r;
    endfunction
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            stage <= '0;
            b_cnt <= '0;
            d_cnt <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_v  <= 1'b0;
            rd_a  <= '0;
            rd_b  <= '0;
            tw    <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                pv[k] <= 1'b0;
                pa[k] <= '0;
                pb[k] <= '0;
            end
`ifdef FFT_CTRL_BITREV_EN
            ov    <= 1'b0;
            oa    <= '0;
            cur_n <= '0;
`endif
        end else if (!i_hold) begin
            pv[0] <= rd_v;
            pa[0] <= rd_a;
            pb[0] <= rd_b;
            for (int k = 1; k < PIPE_LAT; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
            end
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        stage <= '0;
                        b_cnt <= BW'(1);
                        rd_v  <= 1'b1;
                        rd_a  <= c_a;
                        rd_b  <= c_b;
                        tw    <= c_tw;
                    end
                end
                ISSUE: begin
                    rd_v  <= 1'b1;
                    rd_a  <= c_a;
                    rd_b  <= c_b;
                    tw    <= c_tw;
                    b_cnt <= b_cnt + BW'(1);
                    if (b_cnt == BW'(H_MAX - 1)) begin
                        state <= DRAIN;
                        d_cnt <= '0;
                    end
                end
                DRAIN: begin
                    rd_v <= 1'b0;
                    // The last write-back of the stage is on the outputs when d_cnt reaches PIPE_LAT.
                    if (d_cnt == DW'(PIPE_LAT)) begin
                        if (stage == STG_W'(LOG2N - 1)) begin
`ifdef FFT_CTRL_BITREV_EN
                            state <= UNLOAD;
                            ov    <= 1'b1;
                            oa    <= '0;
                            cur_n <= '0;
`else
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            stage <= '0;
`endif
                        end else begin
                            state <= ISSUE;
                            stage <= stage + STG_W'(1);
                            b_cnt <= BW'(1);
                            rd_v  <= 1'b1;
                            rd_a  <= c_a;
                            rd_b  <= c_b;
                            tw    <= c_tw;
                        end
                    end else begin
                        d_cnt <= d_cnt + DW'(1);
                    end
                end
`ifdef FFT_CTRL_BITREV_EN
                UNLOAD: begin
                    if (cur_n == LOG2N'(N - 1)) begin
                        state <= IDLE;
                        ov    <= 1'b0;
                        oa    <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        stage <= '0;
                    end else begin
                        cur_n <= cur_n + LOG2N'(1);
                        oa    <= bitrev(cur_n + LOG2N'(1));
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy      = busy;
    assign o_done      = done;
    assign o_stage     = stage;
    assign o_rd_en     = rd_v & ~i_hold;
    assign o_rd_addr_a = rd_a;
    assign o_rd_addr_b = rd_b;
    assign o_tw_addr   = tw;
    assign o_wr_en     = pv[PIPE_LAT-1] & ~i_hold;
    assign o_wr_addr_a = pa[PIPE_LAT-1];
    assign o_wr_addr_b = pb[PIPE_LAT-1];
`ifdef FFT_CTRL_BITREV_EN
    assign o_out_valid = ov & ~i_hold;
    assign o_out_addr  = oa;
`else
    assign o_out_valid = 1'b0;
    assign o_out_addr  = '0;
`endif

endmodule

// File: tb/tb_fft_stage_seq.sv
// Scoreboard bench for fft_stage_seq (N=32, PIPE_LAT=6): expected strobes are queued with
// the active-edge index at which they must appear; a negedge monitor pops and compares.
module tb_fft_stage_seq;
  localparam int LOG2N = 5;
  localparam int PLAT  = 6;
  localparam int N     = 32;
  localparam int STGP  = N / 2 + PLAT;
`ifdef FFT_CTRL_BITREV_EN
  localparam int DONE_E  = 5 * STGP + N;
  localparam int OUT_EXP = N;
`else
  localparam int DONE_E  = 5 * STGP;
  localparam int OUT_EXP = 0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_start, i_hold;
  logic       o_busy, o_done, o_rd_en, o_wr_en, o_out_valid;
  logic [2:0] o_stage;
  logic [4:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b, o_out_addr;
  logic [3:0] o_tw_addr;

  fft_stage_seq #(.LOG2N(LOG2N), .PIPE_LAT(PLAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_hold(i_hold),
    .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage),
    .o_rd_en(o_rd_en), .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b),
    .o_tw_addr(o_tw_addr), .o_wr_en(o_wr_en), .o_wr_addr_a(o_wr_addr_a),
    .o_wr_addr_b(o_wr_addr_b), .o_out_valid(o_out_valid), .o_out_addr(o_out_addr)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  logic [47:0] rd_q[$];
  logic [47:0] wr_q[$];
  logic [47:0] out_q[$];
  int total = 0, bad = 0;
  int ecnt = 0, wcnt = 0, hold_n = 0;
  int rd_cnt = 0, wr_cnt = 0, out_cnt = 0;
  bit arm = 0, tracking = 0, done_seen = 0, hold_prev = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h ecnt=%0d t=%0t", nm, act, exp, ecnt, $time);
    end
  endtask

  function automatic logic [4:0] brev(input logic [4:0] v);
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[k] = v[4-k];
    return r;
  endfunction

  // Expected run: group/offset form of the DIF butterfly indexing.
  task automatic push_expect();
    int h, g, j, a, b2, t, st;
    rd_q.delete(); wr_q.delete(); out_q.delete();
    for (int s = 0; s < LOG2N; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        h  = N >> (s + 1);
        g  = b / h;
        j  = b % h;
        a  = g * 2 * h + j;
        b2 = a + h;
        t  = (j << s) % (N / 2);
        st = STGP * s + b;
        rd_q.push_back({16'(st), 8'(s), 8'(a), 8'(b2), 8'(t)});
        wr_q.push_back({16'(st + PLAT), 8'd0, 8'(a), 8'(b2), 8'd0});
      end
    end
    for (int n = 0; n < OUT_EXP; n++)
      out_q.push_back({16'(5 * STGP + n), 8'd0, 8'(brev(5'(n))), 16'd0});
  endtask

  // monitor / scoreboard
  always @(negedge i_clk) begin
    logic [47:0] e;
    if (arm) begin
      ecnt = 0; wcnt = 0; arm = 0; tracking = 1;
    end else if (tracking) begin
      wcnt++;
      if (!hold_prev) ecnt++;
    end
    hold_prev = i_hold;
    if (tracking) chk("busy", o_busy, ecnt < DONE_E);
    if (i_hold) chk("strobe_in_hold", {o_rd_en, o_wr_en, o_out_valid}, 3'b000);
    if (o_rd_en) begin
      rd_cnt++;
      if (rd_q.size() == 0) chk("rd_unexp", o_rd_en, 1'b0);
      else begin
        e = rd_q.pop_front();
        chk("rd", {16'(ecnt), 8'(o_stage), 8'(o_rd_addr_a), 8'(o_rd_addr_b), 8'(o_tw_addr)}, e);
      end
      if (ecnt == 3)        chk("dir_s0b3", {o_rd_addr_a, o_rd_addr_b, o_tw_addr}, {5'd3, 5'd19, 4'd3});
      if (ecnt == STGP + 9) chk("dir_s1b9", {o_rd_addr_a, o_rd_addr_b, o_tw_addr}, {5'd17, 5'd25, 4'd2});
      if (ecnt == 4*STGP+3) chk("dir_s4b3", {o_rd_addr_a, o_rd_addr_b, o_tw_addr}, {5'd6, 5'd7, 4'd0});
    end
    if (o_wr_en) begin
      wr_cnt++;
      if (wr_q.size() == 0) chk("wr_unexp", o_wr_en, 1'b0);
      else begin
        e = wr_q.pop_front();
        chk("wr", {16'(ecnt), 8'd0, 8'(o_wr_addr_a), 8'(o_wr_addr_b), 8'd0}, e);
      end
    end
    if (o_out_valid) begin
      out_cnt++;
      if (out_q.size() == 0) chk("out_unexp", o_out_valid, 1'b0);
      else begin
        e = out_q.pop_front();
        chk("out", {16'(ecnt), 8'd0, 8'(o_out_addr), 16'd0}, e);
      end
    end
    if (o_done) begin
      if (!tracking) chk("done_unexp", o_done, 1'b0);
      else begin
        chk("done_edge", ecnt, DONE_E);
        chk("done_wall", wcnt, DONE_E + hold_n);
        chk("done_stage", o_stage, 0);
        tracking = 0;
        done_seen = 1;
      end
    end
  end

  // driver tasks
  task automatic wait_ecnt(input int n);
    int g = 0;
    while (ecnt < n && g < 1000) begin
      @(posedge i_clk);
      g++;
    end
    chk("wait_ecnt_timeout", ecnt >= n, 1'b1);
  endtask

  task automatic start_run(input int hn);
    push_expect();
    rd_cnt = 0; wr_cnt = 0; out_cnt = 0; done_seen = 0; hold_n = hn;
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0; arm = 1;
  endtask

  task automatic finish_run();
    int g = 0;
    while (!done_seen && g < 500) begin
      @(posedge i_clk);
      g++;
    end
    chk("done_timeout", done_seen, 1'b1);
    repeat (3) @(posedge i_clk);
    chk("rd_count", rd_cnt, 80);
    chk("wr_count", wr_cnt, 80);
    chk("out_count", out_cnt, OUT_EXP);
    chk("queues_empty", rd_q.size() + wr_q.size() + out_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_wr_en,
             o_wr_addr_a, o_wr_addr_b, o_out_valid, o_out_addr}, '0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_hold = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #1 chk_all_zero("reset_outputs");
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // run 1: no hold, start re-pulsed while busy
    start_run(0);
    wait_ecnt(50);
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    finish_run();

    // run 2: three held cycles in stage 2
    start_run(3);
    wait_ecnt(50);
    @(posedge i_clk); #1 i_hold = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_hold = 1'b0;
    finish_run();

    // run 3: reset mid-run aborts without write-backs or done
    start_run(0);
    wait_ecnt(40);
    @(posedge i_clk); #1 i_rst_n = 1'b0;
    @(negedge i_clk); #1 tracking = 0;
    rd_q.delete(); wr_q.delete(); out_q.delete();
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk); #1 chk_all_zero("abort_outputs");
    repeat (30) @(posedge i_clk);
    chk("abort_no_done", done_seen, 1'b0);

    // run 4: clean run after abort
    start_run(0);
    finish_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
